qs_mem_rsp: RTL and testbench

Memory-side responder for the sort accelerator's request/response bus. It accepts word reads and writes (valid/ready), serves them from an internal word array mapped at a fixed base address, and returns read data in order after a fixed latency. It sits between the sort core and the user-project memory window, and has a host backdoor port that firmware/testbench uses to preload input data and read back results.

---
 rtl/qs_mem_rsp_pkg.sv | 18 +
 rtl/qs_mem_rsp_if.sv | 16 +
 rtl/qs_mem_rsp_pipe.sv | 34 +++
 rtl/qs_mem_rsp.sv | 143 ++++++++++++++
 tb/tb_qs_mem_rsp.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/qs_mem_rsp_pkg.sv
// Shared types and constants for the sort accelerator memory responder.
package qs_mem_pkg;

  typedef enum logic {
    CLR = 1'b0,
    RUN = 1'b1
  } state_e;

  localparam int unsigned DW       = 32;
  localparam logic [31:0] BASE_DEF = 32'h3800_0180;
  localparam logic [31:0] OUT_BASE = 32'h3800_01c0;

  // Word-index width for an array of the given depth.
  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/qs_mem_rsp_if.sv
// Core-side request/response bus: valid/ready requests, in-order read returns.
interface qs_mem_rsp_if;
  import qs_mem_pkg::*;

  logic          rq_val;
  logic [31:0]   rq_adr;
  logic [DW-1:0] rq_dat;
  logic          rq_wrt;
  logic          rq_rdy;
  logic          rs_val;
  logic [DW-1:0] rs_dat;

  modport master (output rq_val, rq_adr, rq_dat, rq_wrt, input rq_rdy, rs_val, rs_dat);
  modport slave  (input rq_val, rq_adr, rq_dat, rq_wrt, output rq_rdy, rs_val, rs_dat);

endinterface

// File: rtl/qs_mem_rsp_pipe.sv
// Fixed-latency valid/data delay line for read returns; reset empties it at once.
module qs_rsp_pipe #(
  parameter int unsigned LAT = 2,
  parameter int unsigned W   = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_val,
  input  logic [W-1:0] in_dat,
  output logic         out_val,
  output logic [W-1:0] out_dat
);

  logic [LAT-1:0] v;
  logic [W-1:0]   d [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) d[i] <= '0;
    end else begin
      v[0] <= in_val;
      d[0] <= in_dat;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end

  assign out_val = v[LAT-1];
  assign out_dat = d[LAT-1];

endmodule

// File: rtl/qs_mem_rsp.sv
// Word-array memory responder: clears itself after reset, serves core reads/writes
// with in-order fixed-latency returns, and offers a host backdoor port.
module qs_mem_rsp
  import qs_mem_pkg::*;
#(
  parameter logic [31:0] BASE   = BASE_DEF,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned LAT    = 2,
  parameter int unsigned MAXOUT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  qs_mem_rsp_if.slave               bus,
  input  logic                      hs_en,
  input  logic                      hs_wrt,
  input  logic [idx_w(DEPTH)-1:0]   hs_adr,
  input  logic [DW-1:0]             hs_dat,
  output logic [DW-1:0]             hs_rdat,
  output logic                      err,
  output logic [7:0]                wr_cnt,
  output logic                      clr_busy
);

  localparam int unsigned IW = idx_w(DEPTH);
  localparam int unsigned OW = $clog2(MAXOUT + 1);

  state_e          state;
  logic [IW-1:0]   clr_idx;
  logic [DW-1:0]   mem [DEPTH];
  logic [OW-1:0]   outst;

  logic            run;
  logic [31:0]     off;
  logic            in_rng;
  logic [IW-1:0]   rq_idx;
  logic            acc_rd;
  logic            acc_wr;
  logic [DW-1:0]   rd_dat;

  logic            we;
  logic [IW-1:0]   wa;
  logic [DW-1:0]   wd;

  // Address decode against the mapped window.
  assign run    = (state == RUN);
  assign off    = bus.rq_adr - BASE;
  assign in_rng = (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < DEPTH);
  assign rq_idx = off[2 +: IW];
  assign rd_dat = in_rng ? mem[rq_idx] : '0;

  // A return this cycle frees a slot, so accepts can resume on return cycles.
  assign bus.rq_rdy = run && !hs_en && ((outst < OW'(MAXOUT)) || bus.rs_val);
  assign acc_rd     = bus.rq_val && bus.rq_rdy && !bus.rq_wrt;
  assign acc_wr     = bus.rq_val && bus.rq_rdy &&  bus.rq_wrt;

  // Single write port: clear sweep, then host, then core.
  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = '0;
    if (!run) begin
      we = 1'b1;
      wa = clr_idx;
    end else if (hs_en && hs_wrt) begin
      we = 1'b1;
      wa = hs_adr;
      wd = hs_dat;
    end else if (acc_wr && in_rng) begin
      we = 1'b1;
      wa = rq_idx;
      wd = bus.rq_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Clear sweep followed by normal operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLR;
      clr_idx  <= '0;
      clr_busy <= 1'b1;
    end else begin
      case (state)
        CLR: begin
          clr_idx <= clr_idx + IW'(1);
          if (clr_idx == IW'(DEPTH - 1)) begin
            state    <= RUN;
            clr_busy <= 1'b0;
          end
        end
        RUN: ;
        default: state <= CLR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst <= '0;
    end else begin
      case ({acc_rd, bus.rs_val})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase
    end
  end

  // Write counter and sticky decode error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err    <= 1'b0;
      wr_cnt <= '0;
    end else begin
      if (acc_wr && in_rng && (wr_cnt != 8'hFF)) wr_cnt <= wr_cnt + 8'd1;
      if ((acc_wr || acc_rd) && !in_rng)         err    <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_rdat <= '0;
    end else if (run && hs_en && !hs_wrt) begin
      hs_rdat <= mem[hs_adr];
    end
  end

  qs_rsp_pipe #(
    .LAT (LAT),
    .W   (DW)
  ) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_val  (acc_rd),
    .in_dat  (rd_dat),
    .out_val (bus.rs_val),
    .out_dat (bus.rs_dat)
  );

endmodule

// File: tb/tb_qs_mem_rsp.sv
// Scoreboard bench for qs_mem_rsp: default build (A) and a LAT=4/MAXOUT=2 build (B).
module tb_qs_mem_rsp;
  import qs_mem_pkg::*;

  localparam int LAT_A = 2;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qs_mem_rsp_if ifa ();
  qs_mem_rsp_if ifb ();

  logic        hs_en_a = 1'b0, hs_wrt_a = 1'b0, hs_en_b = 1'b0, hs_wrt_b = 1'b0;
  logic [4:0]  hs_adr_a = '0, hs_adr_b = '0;
  logic [31:0] hs_dat_a = '0, hs_dat_b = '0;
  logic [31:0] hs_rdat_a, hs_rdat_b;
  logic        err_a, err_b, clr_busy_a, clr_busy_b;
  logic [7:0]  wr_cnt_a, wr_cnt_b;

  qs_mem_rsp dut_a (
    .clk(clk), .rst(rst), .bus(ifa),
    .hs_en(hs_en_a), .hs_wrt(hs_wrt_a), .hs_adr(hs_adr_a), .hs_dat(hs_dat_a),
    .hs_rdat(hs_rdat_a), .err(err_a), .wr_cnt(wr_cnt_a), .clr_busy(clr_busy_a)
  );

  qs_mem_rsp #(.LAT(LAT_B), .MAXOUT(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb),
    .hs_en(hs_en_b), .hs_wrt(hs_wrt_b), .hs_adr(hs_adr_b), .hs_dat(hs_dat_b),
    .hs_rdat(hs_rdat_b), .err(err_b), .wr_cnt(wr_cnt_b), .clr_busy(clr_busy_b)
  );

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response monitors: pop the oldest expectation on every return.
  always @(negedge clk) begin
    if (!rst && ifa.rs_val) begin
      exp_t e;
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a unexpected rs_val: got data %h with nothing outstanding", ifa.rs_dat);
      end else begin
        e = qa.pop_front();
        chk("a rs_dat", ifa.rs_dat, e.dat);
        chk("a rs cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && ifb.rs_val) begin
      exp_t e;
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b unexpected rs_val: got data %h with nothing outstanding", ifb.rs_dat);
      end else begin
        e = qb.pop_front();
        chk("b rs_dat", ifb.rs_dat, e.dat);
        chk("b rs cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Issue one core request (called #1 after an edge); returns the accept cycle.
  task automatic core_op(input bit sel, input bit wrt, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [31:0] exp,
                         input bit push, output int acc);
    logic r;
    exp_t e;
    if (sel) begin
      ifb.rq_val = 1'b1; ifb.rq_wrt = wrt; ifb.rq_adr = adr; ifb.rq_dat = dat;
    end else begin
      ifa.rq_val = 1'b1; ifa.rq_wrt = wrt; ifa.rq_adr = adr; ifa.rq_dat = dat;
    end
    acc = -1;
    for (int t = 0; t < 100 && acc < 0; t++) begin
      @(negedge clk);
      r = sel ? ifb.rq_rdy : ifa.rq_rdy;
      @(posedge clk);
      #1;
      if (r) acc = cyc;
    end
    if (sel) ifb.rq_val = 1'b0;
    else     ifa.rq_val = 1'b0;
    if (acc < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept timeout: adr %h never accepted, required within 100 cycles", adr);
    end else if (!wrt && push) begin
      e.dat = exp;
      e.cyc = acc + (sel ? LAT_B : LAT_A) - 1;
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
    end
  endtask

  task automatic host_wr(input bit sel, input int idx, input logic [31:0] d);
    if (sel) begin
      hs_en_b = 1'b1; hs_wrt_b = 1'b1; hs_adr_b = 5'(idx); hs_dat_b = d;
    end else begin
      hs_en_a = 1'b1; hs_wrt_a = 1'b1; hs_adr_a = 5'(idx); hs_dat_a = d;
    end
    @(posedge clk);
    #1;
    hs_en_a = 1'b0; hs_wrt_a = 1'b0; hs_en_b = 1'b0; hs_wrt_b = 1'b0;
  endtask

  task automatic host_rd_a(input int idx, input logic [31:0] exp, input string nm);
    hs_en_a = 1'b1; hs_wrt_a = 1'b0; hs_adr_a = 5'(idx);
    @(posedge clk);
    #1;
    hs_en_a = 1'b0;
    chk(nm, hs_rdat_a, exp);
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && (qa.size() + qb.size()) > 0; t++) @(posedge clk);
    #1;
    chk("returns drained", 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] pre [10];
    int acc, first;
    pre = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd0, 32'd8, 32'd2, 32'd6, 32'd5, 32'd4};
    ifa.rq_val = 1'b0; ifa.rq_wrt = 1'b0; ifa.rq_adr = '0; ifa.rq_dat = '0;
    ifb.rq_val = 1'b0; ifb.rq_wrt = 1'b0; ifb.rq_adr = '0; ifb.rq_dat = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst rq_rdy", 32'(ifa.rq_rdy), 32'd0);
    chk("rst rs_val", 32'(ifa.rs_val), 32'd0);
    chk("rst rs_dat", ifa.rs_dat, 32'd0);
    chk("rst hs_rdat", hs_rdat_a, 32'd0);
    chk("rst err", 32'(err_a), 32'd0);
    chk("rst wr_cnt", 32'(wr_cnt_a), 32'd0);
    chk("rst clr_busy", 32'(clr_busy_a), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Clear sweep lasts exactly DEPTH cycles
    repeat (31) @(posedge clk);
    #1;
    chk("clr_busy at 31", 32'(clr_busy_a), 32'd1);
    chk("rq_rdy during clr", 32'(ifa.rq_rdy), 32'd0);
    @(posedge clk);
    #1;
    chk("clr_busy at 32", 32'(clr_busy_a), 32'd0);
    chk("b clr_busy at 32", 32'(clr_busy_b), 32'd0);
    chk("rq_rdy after clr", 32'(ifa.rq_rdy), 32'd1);
    for (int i = 0; i < 32; i++) host_rd_a(i, 32'd0, "host read after clear");

    // Host preload, then back-to-back core reads
    for (int i = 0; i < 10; i++) host_wr(1'b0, i, pre[i]);
    for (int i = 0; i < 8; i++)  host_wr(1'b1, i, 32'hB000_0000 + 32'(i));
    first = 0;
    for (int i = 0; i < 10; i++) begin
      core_op(1'b0, 1'b0, BASE_DEF + 32'(4 * i), '0, pre[i], 1'b1, acc);
      if (i == 0) first = acc;
      else chk("a back-to-back accept", 32'(acc - first), 32'(i));
    end
    drain();

    // Outstanding limit: accepts in pairs, resuming on return cycles
    for (int k = 0; k < 8; k++) begin
      core_op(1'b1, 1'b0, BASE_DEF + 32'(4 * k), '0, 32'hB000_0000 + 32'(k), 1'b1, acc);
      if (k == 0) first = acc;
      chk("b accept cycle", 32'(acc - first), 32'((k / 2) * 4 + (k % 2)));
      chk("b in flight <= 2", 32'(qb.size() <= 2), 32'd1);
    end
    drain();

    // Core writes to the output region, then read-after-write
    for (int i = 0; i < 10; i++)
      core_op(1'b0, 1'b1, OUT_BASE + 32'(4 * i), 32'hA000_0000 + 32'(i), '0, 1'b0, acc);
    core_op(1'b0, 1'b0, OUT_BASE + 32'd36, '0, 32'hA000_0009, 1'b1, acc);
    drain();
    chk("wr_cnt after 10 writes", 32'(wr_cnt_a), 32'd10);
    host_rd_a(16, 32'hA000_0000, "host read idx 16");
    host_rd_a(25, 32'hA000_0009, "host read idx 25");

    // Decode errors
    chk("err before bad access", 32'(err_a), 32'd0);
    core_op(1'b0, 1'b0, 32'h3800_0181, '0, 32'd0, 1'b1, acc);
    core_op(1'b0, 1'b1, 32'h3800_0280, 32'hDEAD_BEEF, '0, 1'b0, acc);
    core_op(1'b0, 1'b0, BASE_DEF, '0, 32'd9, 1'b1, acc);
    drain();
    chk("err after bad access", 32'(err_a), 32'd1);
    chk("wr_cnt unchanged", 32'(wr_cnt_a), 32'd10);
    host_rd_a(0, 32'd9, "dropped write no alias");
    repeat (5) @(posedge clk);
    #1;
    chk("err sticky", 32'(err_a), 32'd1);

    // Host access blocks the core
    ifa.rq_val = 1'b1; ifa.rq_wrt = 1'b0; ifa.rq_adr = BASE_DEF + 32'd4;
    hs_en_a = 1'b1; hs_wrt_a = 1'b0; hs_adr_a = 5'd2;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("rq_rdy under hs_en", 32'(ifa.rq_rdy), 32'd0);
      @(posedge clk);
    end
    #1;
    ifa.rq_val = 1'b0;
    hs_en_a = 1'b0;
    chk("host read under contention", hs_rdat_a, 32'd7);
    repeat (4) @(posedge clk);
    #1;

    // Reset with reads in flight
    core_op(1'b0, 1'b0, BASE_DEF, '0, 32'd9, 1'b1, acc);
    core_op(1'b0, 1'b0, BASE_DEF + 32'd4, '0, '0, 1'b0, acc);
    core_op(1'b0, 1'b0, BASE_DEF + 32'd8, '0, '0, 1'b0, acc);
    chk("rs_val before mid reset", 32'(ifa.rs_val), 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_val drops on reset", 32'(ifa.rs_val), 32'd0);
    chk("only killed reads pending", 32'(qa.size()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    chk("clr_busy after re-clear", 32'(clr_busy_a), 32'd0);
    chk("err cleared by reset", 32'(err_a), 32'd0);
    host_rd_a(0, 32'd0, "idx 0 cleared again");
    host_rd_a(16, 32'd0, "idx 16 cleared again");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
